// File: rtl/div_64bit_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH steps.
// Divide-by-zero finishes immediately with Quotient=all ones, Remainder=Dividend.
module div_64bit_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] b;
    // A kept remainder is always < B, so its top bit is never set and need not be stored.
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   t;
    logic             qbit;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] d_next;

    always_comb begin
        rs     = {r, d[WIDTH-1]};
        t      = rs + ~{1'b0, b} + (WIDTH+1)'(1);
        qbit   = ~t[WIDTH];
        r_next = qbit ? t[WIDTH-1:0] : rs[WIDTH-1:0];
        d_next = {d[WIDTH-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            d           <= '0;
            b           <= '0;
            r           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        d   <= Dividend;
                        b   <= Divisor;
                        r   <= '0;
                        cnt <= '0;
                        if (Divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            Quotient    <= '1;
                            Remainder   <= Dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    r   <= r_next;
                    d   <= d_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        Quotient    <= d_next;
                        Remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_64bit_seq.sv
// Directed and randomized bench for div_64bit_seq; expectations come from
// native 64-bit '/' and '%' plus the divide-by-zero convention.
module tb_div_64bit_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] Dividend;
    logic [63:0] Divisor;
    logic        busy;
    logic        done;
    logic [63:0] Quotient;
    logic [63:0] Remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div_64bit_seq #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Dividend(Dividend), .Divisor(Divisor),
        .busy(busy), .done(done),
        .Quotient(Quotient), .Remainder(Remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_q"}, Quotient, 64'd0);
        chk({tag, "_r"}, Remainder, 64'd0);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
    endtask

    // Reference result from plain arithmetic.
    task automatic model(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output logic z);
        if (b == 64'd0) begin
            q = '1; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endtask

    // Issue one start (DUT must be IDLE or DONE), wait for done, check everything.
    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] eq, er;
        logic        ez;
        int          lat;
        model(a, b, eq, er, ez);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        Dividend = ~a;
        Divisor  = ~b;
        chk({tag, "_busy"}, 64'(busy), 64'(b != 64'd0));
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), (b == 64'd0) ? 64'd1 : 64'd65);
        chk({tag, "_q"}, Quotient, eq);
        chk({tag, "_r"}, Remainder, er);
        chk({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        if (b != 64'd0) begin
            chk({tag, "_ident"}, Quotient * b + Remainder, a);
            chk({tag, "_rltb"}, 64'(Remainder < b), 64'd1);
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v >> $urandom_range(0, 63);
    endfunction

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; Dividend = '0; Divisor = '0;
        tick(); tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic plus hold afterwards.
        do_op("basic", 64'd100, 64'd7);
        tick();
        chk("hold_done", 64'(done), 64'd0);
        tick(); tick();
        chk("hold_q", Quotient, 64'd14);
        chk("hold_r", Remainder, 64'd2);

        do_op("dbz", 64'h1234, 64'd0);
        do_op("ones_by_1", '1, 64'd1);
        do_op("ones_by_ones", '1, '1);
        do_op("small", 64'd5, 64'd9);

        // Start while busy is ignored; no second done follows.
        Dividend = 64'd100; Divisor = 64'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        Dividend = 64'd50; Divisor = 64'd5; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 11; i <= 64; i++) begin
            ndone += int'(done);
            tick();
        end
        chk("ign_done_early", 64'(ndone), 64'd0);
        chk("ign_done_at65", 64'(done), 64'd1);
        chk("ign_q", Quotient, 64'd14);
        chk("ign_r", Remainder, 64'd2);
        ndone = 0;
        repeat (80) begin
            tick();
            ndone += int'(done);
        end
        chk("ign_no_second", 64'(ndone), 64'd0);

        // Reset mid-operation aborts; start on the reset edge is ignored.
        Dividend = 64'd100; Divisor = 64'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        rst_n = 1'b1; start = 1'b0;
        check_reset_outputs("midrst");
        ndone = 0;
        repeat (80) begin
            tick();
            ndone += int'(done);
        end
        chk("midrst_nodone", 64'(ndone), 64'd0);
        do_op("after_rst", 64'd81, 64'd9);

        // Back-to-back randomized operations, each started in the previous DONE cycle.
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a, b;
            a = rnd64();
            b = ($urandom_range(0, 9) == 0) ? 64'd0 : rnd64();
            do_op("rand", a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_64bit_seq.md
# div_64bit_seq

Sequential 64-bit unsigned restoring divider. It is the inverse-operation companion to the 64-bit Vedic multiplier datapath. The block accepts a dividend/divisor pair on a start pulse and produces one quotient bit per clock using a WIDTH+1-bit two's-complement subtract (add of inverted divisor with carry-in 1). It returns quotient and remainder with a one-cycle done pulse, and is used to check and invert multiplier results (Q·B + R == A).

## Interface
- WIDTH, 64, operand/result width in bits. Iteration count equals WIDTH.
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when busy=0
- Dividend  input  WIDTH  unsigned dividend; captured on accepted start
- Divisor  input  WIDTH  unsigned divisor; captured on accepted start
- busy  output  1  high while in CALC
- done  output  1  one-cycle pulse; results valid this cycle and held afterwards
- Quotient  output  WIDTH  unsigned quotient
- Remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set with done when the captured Divisor == 0

## Operation
- States: IDLE, CALC, DONE. Reset (rst_n=0 at an edge) forces IDLE.
- Reset values: busy=0, done=0, Quotient=0, Remainder=0, div_by_zero=0. Internal counter, partial remainder and shift register are cleared.
- IDLE or DONE with start=1:
  - Capture Dividend into shift register D and Divisor into register B.
  - Clear partial remainder R (WIDTH+1 bits) and the iteration counter.
  - If B==0, go to DONE. Otherwise go to CALC.
- IDLE or DONE with start=0: go to/stay IDLE.
- Start while busy=1 is ignored entirely. Captured operands are unaffected.
- CALC step, one per edge:
  - Rs = {R[WIDTH-1:0], D[WIDTH-1]}
  - T = Rs + ~{1'b0,B} + 1, computed over WIDTH+1 bits
  - If T[WIDTH]==0 (Rs >= B): R=T and qbit=1. Else: R=Rs and qbit=0.
  - D = {D[WIDTH-2:0], qbit}
  - The counter increments. After the WIDTH-th step, go to DONE.
- Entering DONE from CALC: Quotient=D (post-step), Remainder=R[WIDTH-1:0], div_by_zero=0.
- Entering DONE on divide-by-zero: Quotient = all ones, Remainder = captured Dividend, div_by_zero=1.
- Quotient, Remainder and div_by_zero change only on entry to DONE or on reset. Otherwise they hold, including through a subsequent CALC.
- Arithmetic: all unsigned. The result always satisfies Quotient·Divisor + Remainder == Dividend and Remainder < Divisor (for Divisor≠0). No overflow case exists.

## Timing
- Let E0 be the edge that accepts start.
- Normal case: busy=1 from E0 through the edge performing step WIDTH (E_WIDTH). done=1 for exactly the cycle after E_WIDTH (sampled high at E_WIDTH+1). Latency is WIDTH+1 edges start-to-sampled-done, i.e. 65 for the default.
- Divide-by-zero: busy never asserts. done is sampled high at E1.
- done is a single-cycle pulse. It is never asserted for two consecutive cycles, except when back-to-back divide-by-zero starts issue in DONE.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge. The next operation's done follows with the same latency, with no idle cycle required.
- rst_n low at any edge (including mid-CALC or in DONE) aborts the operation. The next cycle shows all outputs at reset values and the FSM is in IDLE. Start is ignored on an edge where rst_n=0.
- Operand inputs need only be valid on the accepting edge. Later changes have no effect.

## Test plan
- Basic: Dividend=100, Divisor=7, 1-cycle start → busy for 64 cycles. done sampled at E65 with Quotient=14, Remainder=2, div_by_zero=0. Outputs held until next start.
- Divide-by-zero: Dividend=0x1234, Divisor=0 → done at E1 with Quotient=0xFFFF_FFFF_FFFF_FFFF, Remainder=0x1234, div_by_zero=1. busy stays 0.
- Extremes:
  - Dividend=0xFFFF_FFFF_FFFF_FFFF, Divisor=1 → Q=all ones, R=0.
  - Divisor=0xFFFF_FFFF_FFFF_FFFF, same dividend → Q=1, R=0.
  - Dividend=5, Divisor=9 → Q=0, R=5.
- Start while busy: issue 100/7, then at cycle 10 pulse start with 50/5 → ignored. Result is Q=14, R=2 at E65, and no second done follows.
- Reset mid-operation: rst_n=0 for one edge at cycle 30 of a divide → next cycle busy=0, done=0, Q=R=0. done never asserts for the aborted op. A new 81/9 then yields Q=9, R=0 at the normal latency.
- Back-to-back plus random: start asserted in each DONE cycle for 1000 random pairs (including Divisor=0) → every result satisfies Q·B+R==A and R<B, with one done per accepted start.
